imu_spi_master: RTL and testbench

SPI master that generates the serial clock, chip select and command stream for one 16-bit IMU register transaction. Sits directly upstream of the 16-bit serial-in/parallel-out capture register. That register samples MISO on the falling edge of `sclk` produced here. `done` tells the consumer that the captured word is complete and stable.

---
 rtl/imu_spi_pkg.sv | 16 +
 rtl/imu_spi_if.sv | 9 +
 rtl/spi_clk_div.sv | 17 +
 rtl/imu_spi_master.sv | 86 ++++++++
 tb/tb_imu_spi_master.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/imu_spi_pkg.sv
// imu_spi_pkg: shared states, frame layout and frame builder for the IMU SPI master.
package imu_spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  localparam int FRAME_BITS = 16;
  localparam int DEFAULT_CLK_DIV = 4;
  localparam int RW_BIT = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    frame_word = '0;
    frame_word[RW_BIT] = rw;
    frame_word[ADDR_MSB:ADDR_LSB] = addr;
    frame_word[DATA_MSB:0] = rw ? 8'h00 : data;
  endfunction
endpackage

// File: rtl/imu_spi_if.sv
// imu_spi_if: command handshake and SPI pins of the IMU SPI master.
interface imu_spi_if;
  logic start, rw;
  logic [6:0] addr;
  logic [7:0] wr_data;
  logic busy, done, sclk, cs_n, mosi;
  modport master (input start, rw, addr, wr_data, output busy, done, sclk, cs_n, mosi);
  modport slave (output start, rw, addr, wr_data, input busy, done, sclk, cs_n, mosi);
endinterface

// File: rtl/spi_clk_div.sv
// spi_clk_div: free-running half-period tick, held at phase zero while clr is high.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/imu_spi_master.sv
// imu_spi_master: SPI mode-1 master issuing one 16-bit IMU register frame per start.
module imu_spi_master #(
  parameter int CLK_DIV = imu_spi_pkg::DEFAULT_CLK_DIV,
  parameter int FRAME_BITS = imu_spi_pkg::FRAME_BITS
) (
  input logic clk,
  input logic rst_n,
  imu_spi_if.master bus
);
  import imu_spi_pkg::*;
  state_t state, state_nx;
  logic [FRAME_BITS-1:0] sr, sr_nx;
  logic [4:0] edges, edges_nx;
  logic sclk_nx, cs_n_nx, mosi_nx, busy_nx, done_nx, tick;
  // Divider phase is pinned to zero in IDLE so every phase starts aligned to the accept edge.
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (.clk(clk), .rst_n(rst_n), .clr(state == IDLE), .tick(tick));
  always_comb begin
    state_nx = state;
    sr_nx = sr;
    edges_nx = edges;
    sclk_nx = bus.sclk;
    cs_n_nx = bus.cs_n;
    mosi_nx = bus.mosi;
    busy_nx = bus.busy;
    done_nx = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_nx = SETUP;
        sr_nx = frame_word(bus.rw, bus.addr, bus.wr_data);
        edges_nx = '0;
        busy_nx = 1'b1;
        cs_n_nx = 1'b0;
      end
      SETUP: if (tick) begin
        state_nx = SHIFT;
        sclk_nx = 1'b1;
        mosi_nx = sr[FRAME_BITS-1];
        sr_nx = sr << 1;
      end
      // The low half after the last falling edge stays in SHIFT before HOLD begins.
      SHIFT: if (tick) begin
        if (bus.sclk) begin
          sclk_nx = 1'b0;
          edges_nx = edges + 5'd1;
        end else if (edges == 5'(FRAME_BITS)) begin
          state_nx = HOLD;
          mosi_nx = 1'b0;
        end else begin
          sclk_nx = 1'b1;
          mosi_nx = sr[FRAME_BITS-1];
          sr_nx = sr << 1;
        end
      end
      HOLD: if (tick) begin
        state_nx = GAP;
        cs_n_nx = 1'b1;
        done_nx = 1'b1;
      end
      GAP: if (tick) begin
        state_nx = IDLE;
        busy_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sr <= '0;
      edges <= '0;
      bus.sclk <= 1'b0;
      bus.cs_n <= 1'b1;
      bus.mosi <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= state_nx;
      sr <= sr_nx;
      edges <= edges_nx;
      bus.sclk <= sclk_nx;
      bus.cs_n <= cs_n_nx;
      bus.mosi <= mosi_nx;
      bus.busy <= busy_nx;
      bus.done <= done_nx;
    end
endmodule

// File: tb/tb_imu_spi_master.sv
// tb_imu_spi_master: directed checks of frame content, timing, busy lockout and reset abort.
module tb_imu_spi_master;
  logic clk = 0, rst_n = 0, sel = 0;
  logic m_sclk, m_cs_n, m_mosi, m_busy, m_done;
  logic [15:0] cap = '0, r_word;
  int n_cmp = 0, n_bad = 0;
  int r_done_at, r_done_n, r_busy0_at, r_pulses, r_bad, r_fall1;
  imu_spi_if if4();
  imu_spi_if if2();
  imu_spi_master #(.CLK_DIV(4)) d4 (.clk(clk), .rst_n(rst_n), .bus(if4.master));
  imu_spi_master #(.CLK_DIV(2)) d2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));
  always #5 clk = ~clk;
  assign m_sclk = sel ? if2.sclk : if4.sclk;
  assign m_cs_n = sel ? if2.cs_n : if4.cs_n;
  assign m_mosi = sel ? if2.mosi : if4.mosi;
  assign m_busy = sel ? if2.busy : if4.busy;
  assign m_done = sel ? if2.done : if4.done;
  // Downstream capture register fed by mosi loopback, sampling on sclk falling edges.
  always @(negedge m_sclk) if (!m_cs_n) cap <= {cap[14:0], m_mosi};

  task automatic go(input logic s, input logic rw, input logic [6:0] a, input logic [7:0] wd);
    sel = s;
    if (s) begin if2.rw = rw; if2.addr = a; if2.wr_data = wd; if2.start = 1; end
    else begin if4.rw = rw; if4.addr = a; if4.wr_data = wd; if4.start = 1; end
    @(posedge clk); #1;
    if2.start = 0; if4.start = 0;
  endtask

  // Observes periods p=1.. after the accept edge; p is the value sampled on edge p.
  task automatic run_frame(input int d, input int poke_at);
    logic ps = 0, pm = 0;
    int hi = 0, lo = 0;
    r_word = '0; r_done_at = -1; r_done_n = 0; r_busy0_at = -1; r_pulses = 0; r_bad = 0; r_fall1 = -1;
    for (int p = 1; p <= 40 * d; p++) begin
      if (p == poke_at) begin if4.start = 1; if4.addr = 7'h55; end
      if (p == poke_at + 1) if4.start = 0;
      if (m_done) begin r_done_n++; if (r_done_at < 0) r_done_at = p; end
      if (!m_busy && r_busy0_at < 0) r_busy0_at = p;
      if (m_sclk) begin
        if (!ps && r_pulses > 0 && lo != d) r_bad++;
        hi = ps ? hi + 1 : 1;
      end else begin
        if (ps) begin
          r_pulses++;
          r_word = {r_word[14:0], pm};
          if (hi != d) r_bad++;
          if (r_fall1 < 0) r_fall1 = p;
        end
        lo = ps ? 1 : lo + 1;
      end
      if (m_cs_n && !m_done && r_done_at < 0) r_bad++;
      ps = m_sclk; pm = m_mosi;
      if (r_busy0_at >= 0) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_cmp++; if ({if4.sclk, if4.cs_n, if4.mosi, if4.busy, if4.done} !== 5'b01000) begin n_bad++; $display("FAIL reset_d4 got %b want 01000", {if4.sclk, if4.cs_n, if4.mosi, if4.busy, if4.done}); end
    n_cmp++; if ({if2.sclk, if2.cs_n, if2.mosi, if2.busy, if2.done} !== 5'b01000) begin n_bad++; $display("FAIL reset_d2 got %b want 01000", {if2.sclk, if2.cs_n, if2.mosi, if2.busy, if2.done}); end
    sel = 0; if4.rw = 1; if4.addr = 7'h3B; if4.wr_data = 8'h00; if4.start = 1;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    if4.start = 0;
    n_cmp++; if ({if4.busy, if4.cs_n} !== 2'b10) begin n_bad++; $display("FAIL first_edge_accept got busy,cs_n=%b want 10", {if4.busy, if4.cs_n}); end
    run_frame(4, 0);
    n_cmp++; if (r_done_at !== 137) begin n_bad++; $display("FAIL post_reset_done got %0d want 137", r_done_at); end
  endtask

  task automatic test_read();
    go(0, 1, 7'h3B, 8'hFF);
    run_frame(4, 0);
    n_cmp++; if (r_word !== 16'hBB00) begin n_bad++; $display("FAIL read_word got %h want bb00", r_word); end
    n_cmp++; if (r_done_at !== 137) begin n_bad++; $display("FAIL read_done_at got %0d want 137", r_done_at); end
    n_cmp++; if (r_pulses !== 16) begin n_bad++; $display("FAIL read_pulses got %0d want 16", r_pulses); end
    n_cmp++; if (r_bad !== 0) begin n_bad++; $display("FAIL read_shape got %0d bad want 0", r_bad); end
    n_cmp++; if (r_fall1 !== 9) begin n_bad++; $display("FAIL read_first_fall got %0d want 9", r_fall1); end
    n_cmp++; if (r_busy0_at !== 141) begin n_bad++; $display("FAIL read_busy_low got %0d want 141", r_busy0_at); end
    n_cmp++; if (cap !== 16'hBB00) begin n_bad++; $display("FAIL read_loopback got %h want bb00", cap); end
  endtask

  task automatic test_write();
    go(1, 0, 7'h6B, 8'h01);
    run_frame(2, 0);
    n_cmp++; if (r_word !== 16'h6B01) begin n_bad++; $display("FAIL write_word got %h want 6b01", r_word); end
    n_cmp++; if (r_done_at !== 69) begin n_bad++; $display("FAIL write_done_at got %0d want 69", r_done_at); end
    n_cmp++; if (r_busy0_at !== 71) begin n_bad++; $display("FAIL write_busy_low got %0d want 71", r_busy0_at); end
    n_cmp++; if (r_pulses !== 16 || r_bad !== 0) begin n_bad++; $display("FAIL write_shape got pulses=%0d bad=%0d want 16/0", r_pulses, r_bad); end
    n_cmp++; if (cap !== 16'h6B01) begin n_bad++; $display("FAIL write_loopback got %h want 6b01", cap); end
  endtask

  task automatic test_back_to_back();
    go(0, 1, 7'h3B, 8'h00);
    run_frame(4, 0);
    go(0, 0, 7'h6B, 8'h01);
    run_frame(4, 0);
    n_cmp++; if (r_word !== 16'h6B01) begin n_bad++; $display("FAIL b2b_word got %h want 6b01", r_word); end
    n_cmp++; if (r_done_at !== 137 || r_bad !== 0) begin n_bad++; $display("FAIL b2b_timing got done=%0d bad=%0d want 137/0", r_done_at, r_bad); end
  endtask

  task automatic test_busy_ignore();
    int viol = 0;
    go(0, 1, 7'h3B, 8'h00);
    run_frame(4, 40);
    if4.addr = 7'h3B;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (if4.busy || !if4.cs_n || if4.done) viol++;
    end
    n_cmp++; if (r_word !== 16'hBB00) begin n_bad++; $display("FAIL ignore_word got %h want bb00", r_word); end
    n_cmp++; if (r_done_n !== 1) begin n_bad++; $display("FAIL ignore_done_count got %0d want 1", r_done_n); end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL ignore_no_second_frame got %0d active cycles want 0", viol); end
    n_cmp++; if (cap !== 16'hBB00) begin n_bad++; $display("FAIL ignore_loopback got %h want bb00", cap); end
  endtask

  task automatic test_reset_mid();
    int falls = 0, viol = 0;
    logic ps = 0;
    go(0, 1, 7'h3B, 8'h00);
    for (int p = 1; p < 300 && falls < 8; p++) begin
      if (ps && !m_sclk) falls++;
      ps = m_sclk;
      if (falls < 8) begin @(posedge clk); #1; end
    end
    n_cmp++; if (falls !== 8) begin n_bad++; $display("FAIL midreset_reach got %0d falls want 8", falls); end
    rst_n = 0; #1;
    n_cmp++; if ({if4.sclk, if4.cs_n, if4.mosi, if4.busy, if4.done} !== 5'b01000) begin n_bad++; $display("FAIL midreset_outputs got %b want 01000", {if4.sclk, if4.cs_n, if4.mosi, if4.busy, if4.done}); end
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (if4.done || !if4.cs_n) viol++;
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL midreset_quiet got %0d active cycles want 0", viol); end
    go(0, 0, 7'h6B, 8'h01);
    run_frame(4, 0);
    n_cmp++; if (r_word !== 16'h6B01 || r_done_at !== 137) begin n_bad++; $display("FAIL midreset_recover got %h done=%0d want 6b01/137", r_word, r_done_at); end
    n_cmp++; if (cap !== 16'h6B01) begin n_bad++; $display("FAIL midreset_loopback got %h want 6b01", cap); end
  endtask

  initial begin
    if4.start = 0; if4.rw = 0; if4.addr = '0; if4.wr_data = '0;
    if2.start = 0; if2.rw = 0; if2.addr = '0; if2.wr_data = '0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
